// File: rtl/secmem_wb_master_if.sv
// Wishbone bus bundle between the secure-memory command master and its slave.
// The master modport drives the cycle controls; the slave modport answers with ack/data.
interface secmem_wb_master_if #(
  parameter int ADDR_WD = 8,
  parameter int DATA_WD = 32
);
  logic               wb_cyc_o;
  logic               wb_stb_o;
  logic               wb_we_o;
  logic [ADDR_WD-1:0] wb_adr_o;
  logic [DATA_WD-1:0] wb_dat_o;
  logic [3:0]         wb_sel_o;
  logic [DATA_WD-1:0] wb_dat_i;
  logic               wb_ack_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/secmem_wb_master.sv
// Command-driven Wishbone master for a secure-memory block: key/data writes,
// data reads with status polling, per-cycle ack timeout and a bounded poll count.
module secmem_wb_master #(
  parameter int ADDR_WD  = 8,
  parameter int DATA_WD  = 32,
  parameter int ACK_TO   = 16,
  parameter int POLL_MAX = 64
) (
  input  logic               wb_clk_i,
  input  logic               rst,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [1:0]         cmd_op_i,
  input  logic [ADDR_WD-1:0] cmd_addr_i,
  input  logic [DATA_WD-1:0] cmd_data_i,
  output logic               rsp_valid_o,
  output logic [DATA_WD-1:0] rsp_data_o,
  output logic [1:0]         rsp_err_o,
  secmem_wb_master_if.master wb
);

  localparam int ACK_W  = $clog2(ACK_TO + 1);
  localparam int POLL_W = $clog2(POLL_MAX + 1);

  localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TO - 1);
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);
  localparam logic [POLL_W-1:0] POLL_SAT  = POLL_W'(POLL_MAX);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ACK_TO  = 2'b01;
  localparam logic [1:0] ERR_POLL    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  localparam logic [ADDR_WD-1:0] ADR_KEY    = ADDR_WD'(0);
  localparam logic [ADDR_WD-1:0] ADR_RDATA  = ADDR_WD'(1);
  localparam logic [ADDR_WD-1:0] ADR_STATUS = ADDR_WD'(2);

  typedef enum logic [2:0] {
    IDLE,
    KEY_WR,
    DAT_WR,
    DAT_RD,
    POLL,
    FETCH,
    RESP
  } state_t;

  state_t state_reg, state_next;

  logic               cyc_reg, cyc_next;
  logic               stb_reg, stb_next;
  logic               we_reg, we_next;
  logic [ADDR_WD-1:0] adr_reg, adr_next;
  logic [DATA_WD-1:0] dat_reg, dat_next;
  logic [3:0]         sel_reg, sel_next;

  logic [ACK_W-1:0]   ack_cnt_reg, ack_cnt_next;
  logic [POLL_W-1:0]  poll_cnt_reg, poll_cnt_next;
  logic [1:0]         err_reg, err_next;
  logic [DATA_WD-1:0] rdata_reg, rdata_next;

  logic [ADDR_WD-1:0] cmd_addr_reg, cmd_addr_next;
  logic [DATA_WD-1:0] cmd_data_reg, cmd_data_next;
  logic               cmd_rd_reg, cmd_rd_next;

  // Per-state target of the Wishbone cycle this state issues.
  logic [ADDR_WD-1:0] tgt_adr;
  logic               tgt_we;
  logic [DATA_WD-1:0] tgt_dat;
  logic               bus_state;
  logic               bus_done;
  logic               bus_timeout;
  logic               bus_drop;
  logic               status_busy;

  assign cmd_ready_o = (state_reg == IDLE);
  assign rsp_valid_o = (state_reg == RESP);
  assign rsp_data_o  = rdata_reg;
  assign rsp_err_o   = err_reg;

  assign wb.wb_cyc_o = cyc_reg;
  assign wb.wb_stb_o = stb_reg;
  assign wb.wb_we_o  = we_reg;
  assign wb.wb_adr_o = adr_reg;
  assign wb.wb_dat_o = dat_reg;
  assign wb.wb_sel_o = sel_reg;

  // Writes watch wr_busy (bit 0), reads watch rd_busy (bit 1).
  assign status_busy = cmd_rd_reg ? wb.wb_dat_i[1] : wb.wb_dat_i[0];

  assign bus_state = (state_reg inside {KEY_WR, DAT_WR, DAT_RD, POLL, FETCH});

  always_ff @(posedge wb_clk_i) begin
    if (rst) begin
      state_reg    <= IDLE;
      cyc_reg      <= 1'b0;
      stb_reg      <= 1'b0;
      we_reg       <= 1'b0;
      adr_reg      <= '0;
      dat_reg      <= '0;
      sel_reg      <= 4'h0;
      ack_cnt_reg  <= '0;
      poll_cnt_reg <= '0;
      err_reg      <= ERR_OK;
      rdata_reg    <= '0;
      cmd_addr_reg <= '0;
      cmd_data_reg <= '0;
      cmd_rd_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cyc_reg      <= cyc_next;
      stb_reg      <= stb_next;
      we_reg       <= we_next;
      adr_reg      <= adr_next;
      dat_reg      <= dat_next;
      sel_reg      <= sel_next;
      ack_cnt_reg  <= ack_cnt_next;
      poll_cnt_reg <= poll_cnt_next;
      err_reg      <= err_next;
      rdata_reg    <= rdata_next;
      cmd_addr_reg <= cmd_addr_next;
      cmd_data_reg <= cmd_data_next;
      cmd_rd_reg   <= cmd_rd_next;
    end
  end

  always_comb begin
    tgt_adr = ADR_KEY;
    tgt_we  = 1'b0;
    tgt_dat = '0;
    unique case (state_reg)
      KEY_WR: begin
        tgt_we  = 1'b1;
        tgt_dat = cmd_data_reg;
      end
      DAT_WR: begin
        tgt_adr = cmd_addr_reg;
        tgt_we  = 1'b1;
        tgt_dat = cmd_data_reg;
      end
      DAT_RD:  tgt_adr = cmd_addr_reg;
      POLL:    tgt_adr = ADR_STATUS;
      FETCH:   tgt_adr = ADR_RDATA;
      default: tgt_adr = ADR_KEY;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    cyc_next      = cyc_reg;
    stb_next      = stb_reg;
    we_next       = we_reg;
    adr_next      = adr_reg;
    dat_next      = dat_reg;
    sel_next      = sel_reg;
    ack_cnt_next  = ack_cnt_reg;
    poll_cnt_next = poll_cnt_reg;
    err_next      = err_reg;
    rdata_next    = rdata_reg;
    cmd_addr_next = cmd_addr_reg;
    cmd_data_next = cmd_data_reg;
    cmd_rd_next   = cmd_rd_reg;
    bus_done      = 1'b0;
    bus_timeout   = 1'b0;
    bus_drop      = 1'b0;

    // A bus state enters with cyc low, which provides the idle cycle between
    // Wishbone cycles; the cycle is launched from that idle cycle.
    if (bus_state) begin
      if (!cyc_reg) begin
        cyc_next     = 1'b1;
        stb_next     = 1'b1;
        we_next      = tgt_we;
        adr_next     = tgt_adr;
        dat_next     = tgt_dat;
        sel_next     = 4'hF;
        ack_cnt_next = '0;
      end else if (wb.wb_ack_i) begin
        bus_done = 1'b1;
        bus_drop = 1'b1;
      end else if (ack_cnt_reg == ACK_LAST) begin
        bus_timeout = 1'b1;
        bus_drop    = 1'b1;
      end else begin
        ack_cnt_next = ack_cnt_reg + ACK_W'(1);
      end
    end

    if (bus_drop) begin
      cyc_next = 1'b0;
      stb_next = 1'b0;
      we_next  = 1'b0;
      adr_next = '0;
      dat_next = '0;
      sel_next = 4'h0;
    end

    unique case (state_reg)
      IDLE: begin
        if (cmd_valid_i) begin
          cmd_addr_next = cmd_addr_i;
          cmd_data_next = cmd_data_i;
          cmd_rd_next   = (cmd_op_i == 2'b10);
          poll_cnt_next = '0;
          ack_cnt_next  = '0;
          rdata_next    = '0;
          err_next      = ERR_OK;
          unique case (cmd_op_i)
            2'b00:   state_next = KEY_WR;
            2'b01:   state_next = DAT_WR;
            2'b10:   state_next = DAT_RD;
            default: begin
              state_next = RESP;
              err_next   = ERR_ILLEGAL;
            end
          endcase
        end
      end
      KEY_WR: begin
        if (bus_done) state_next = RESP;
      end
      DAT_WR, DAT_RD: begin
        if (bus_done) state_next = POLL;
      end
      POLL: begin
        if (bus_done) begin
          if (!status_busy) begin
            state_next = cmd_rd_reg ? FETCH : RESP;
          end else if (poll_cnt_reg >= POLL_LAST) begin
            poll_cnt_next = POLL_SAT;
            state_next    = RESP;
            err_next      = ERR_POLL;
          end else begin
            poll_cnt_next = poll_cnt_reg + POLL_W'(1);
          end
        end
      end
      FETCH: begin
        if (bus_done) begin
          rdata_next = wb.wb_dat_i;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (bus_timeout) begin
      state_next = RESP;
      err_next   = ERR_ACK_TO;
    end
  end

endmodule

// File: tb/tb_secmem_wb_master.sv
// Directed bench for secmem_wb_master: a scripted Wishbone slave plus a
// protocol/response monitor, both acting on the falling clock edge.
module tb_secmem_wb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [7:0]  cmd_addr = 8'h00;
  logic [31:0] cmd_data = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;

  secmem_wb_master_if #(.ADDR_WD(8), .DATA_WD(32)) bus ();

  secmem_wb_master #(.ADDR_WD(8), .DATA_WD(32), .ACK_TO(16), .POLL_MAX(64)) dut (
    .wb_clk_i    (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_addr_i  (cmd_addr),
    .cmd_data_i  (cmd_data),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .wb          (bus.master)
  );

  always #5 clk = ~clk;

  int n_compared = 0;
  int n_mismatched = 0;

  // Slave configuration, written only by the stimulus block.
  int ack_lat = 2;
  bit ack_en = 1'b1;
  int busy_n = 0;
  logic [31:0] busy_val = 32'h0;
  int st_base = 0;

  // Counters and captures, written only by the slave/monitor block.
  int wr_cnt = 0, st_cnt = 0, fetch_cnt = 0, rd_cnt = 0, cyc_hi = 0, rsp_cnt = 0, viol = 0;
  int wait_cnt = 0;
  logic [7:0]  last_wr_adr = 8'h0, last_rd_adr = 8'h0;
  logic [31:0] last_wr_dat = 32'h0;
  logic [3:0]  last_wr_sel = 4'h0;
  logic [1:0]  last_err = 2'b00;
  logic [31:0] last_data = 32'h0;
  logic        prev_cyc = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [7:0]  prev_adr = 8'h0;
  logic [31:0] prev_dat = 32'h0;

  initial begin
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = 32'h0;
  end

  always @(negedge clk) begin
    if (bus.wb_cyc_o === 1'b1) begin
      cyc_hi++;
      if (bus.wb_sel_o !== 4'hF || bus.wb_stb_o !== 1'b1) viol++;
      if (prev_cyc && !prev_ack &&
          (bus.wb_adr_o !== prev_adr || bus.wb_dat_o !== prev_dat || bus.wb_we_o !== prev_we)) viol++;
      if (prev_cyc && prev_ack) viol++;
    end
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      last_err  = rsp_err;
      last_data = rsp_data;
    end
    prev_cyc = (bus.wb_cyc_o === 1'b1);
    prev_ack = bus.wb_ack_i;
    prev_adr = bus.wb_adr_o;
    prev_dat = bus.wb_dat_o;
    prev_we  = bus.wb_we_o;

    bus.wb_ack_i = 1'b0;
    if (bus.wb_cyc_o === 1'b1 && bus.wb_stb_o === 1'b1 && ack_en) begin
      if (wait_cnt >= ack_lat) begin
        bus.wb_ack_i = 1'b1;
        wait_cnt = 0;
        if (bus.wb_we_o) begin
          wr_cnt++;
          last_wr_adr = bus.wb_adr_o;
          last_wr_dat = bus.wb_dat_o;
          last_wr_sel = bus.wb_sel_o;
        end else if (bus.wb_adr_o == 8'd2) begin
          bus.wb_dat_i = ((st_cnt - st_base) < busy_n) ? busy_val : 32'h0;
          st_cnt++;
        end else if (bus.wb_adr_o == 8'd1) begin
          bus.wb_dat_i = 32'hDEADBEEF;
          fetch_cnt++;
        end else begin
          bus.wb_dat_i = 32'hA5A5_0000;
          rd_cnt++;
          last_rd_adr = bus.wb_adr_o;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  int b_wr, b_st, b_fetch, b_rd, b_cyc, b_rsp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_wr = wr_cnt; b_st = st_cnt; b_fetch = fetch_cnt;
    b_rd = rd_cnt; b_cyc = cyc_hi; b_rsp = rsp_cnt;
    st_base = st_cnt;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d,
                       input bit wait_rsp);
    int guard;
    snap();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (wait_rsp) begin
      guard = 0;
      while (rsp_cnt == b_rsp && guard < 3000) begin
        @(negedge clk);
        guard++;
      end
      repeat (3) @(negedge clk);
      check("rsp_pulse_count", 32'(rsp_cnt - b_rsp), 32'd1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cyc",       32'(bus.wb_cyc_o), 32'd0);
    check("rst_stb",       32'(bus.wb_stb_o), 32'd0);
    check("rst_we",        32'(bus.wb_we_o),  32'd0);
    check("rst_adr",       32'(bus.wb_adr_o), 32'd0);
    check("rst_dat",       bus.wb_dat_o,      32'd0);
    check("rst_sel",       32'(bus.wb_sel_o), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid),    32'd0);
    check("rst_rsp_data",  rsp_data,          32'd0);
    check("rst_rsp_err",   32'(rsp_err),      32'd0);
    check("rst_cmd_ready", 32'(cmd_ready),    32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    $display("step reset: outputs checked");

    ack_lat = 2;
    issue(2'b00, 8'h55, 32'h1234_5678, 1'b1);
    check("key_wr_count", 32'(wr_cnt - b_wr), 32'd1);
    check("key_wr_adr",   32'(last_wr_adr),   32'd0);
    check("key_wr_dat",   last_wr_dat,        32'h1234_5678);
    check("key_wr_sel",   32'(last_wr_sel),   32'hF);
    check("key_status_rd", 32'(st_cnt - b_st), 32'd0);
    check("key_err",      32'(last_err),      32'd0);
    check("key_data",     last_data,          32'd0);
    $display("step key write: err=%0d", last_err);

    busy_n = 2; busy_val = 32'h1;
    issue(2'b01, 8'h10, 32'hCAFE_F00D, 1'b1);
    check("dwr_count",     32'(wr_cnt - b_wr),  32'd1);
    check("dwr_adr",       32'(last_wr_adr),    32'h10);
    check("dwr_dat",       last_wr_dat,         32'hCAFE_F00D);
    check("dwr_status_rd", 32'(st_cnt - b_st),  32'd3);
    check("dwr_err",       32'(last_err),       32'd0);
    check("dwr_fetch",     32'(fetch_cnt - b_fetch), 32'd0);
    $display("step data write: status reads=%0d", st_cnt - b_st);

    busy_n = 1; busy_val = 32'h2;
    issue(2'b10, 8'h20, 32'h0, 1'b1);
    check("drd_rd_count",  32'(rd_cnt - b_rd),  32'd1);
    check("drd_rd_adr",    32'(last_rd_adr),    32'h20);
    check("drd_status_rd", 32'(st_cnt - b_st),  32'd2);
    check("drd_fetch",     32'(fetch_cnt - b_fetch), 32'd1);
    check("drd_data",      last_data,           32'hDEADBEEF);
    check("drd_err",       32'(last_err),       32'd0);
    $display("step data read: data=%h", last_data);

    // rd_busy set but wr_busy clear: a write must finish after one status read.
    busy_n = 5; busy_val = 32'h2;
    issue(2'b01, 8'h11, 32'h0000_0042, 1'b1);
    check("dwr_watch_status_rd", 32'(st_cnt - b_st), 32'd1);
    check("dwr_watch_data",      last_data,          32'd0);
    check("dwr_watch_err",       32'(last_err),      32'd0);
    $display("step write watches bit0: status reads=%0d", st_cnt - b_st);

    busy_n = 5; busy_val = 32'h1;
    issue(2'b10, 8'h21, 32'h0, 1'b1);
    check("drd_watch_status_rd", 32'(st_cnt - b_st), 32'd1);
    check("drd_watch_data",      last_data,          32'hDEADBEEF);
    $display("step read watches bit1: status reads=%0d", st_cnt - b_st);

    ack_en = 1'b0;
    issue(2'b01, 8'h12, 32'h1, 1'b1);
    check("noack_cyc_cycles", 32'(cyc_hi - b_cyc), 32'd16);
    check("noack_err",        32'(last_err),       32'd1);
    check("noack_data",       last_data,           32'd0);
    check("noack_cyc_low",    32'(bus.wb_cyc_o),   32'd0);
    ack_en = 1'b1;
    $display("step no ack: cyc cycles=%0d err=%0d", cyc_hi - b_cyc, last_err);

    ack_lat = 15;
    issue(2'b00, 8'h00, 32'h0BAD_0001, 1'b1);
    check("late_ack_wr",  32'(wr_cnt - b_wr),   32'd1);
    check("late_ack_err", 32'(last_err),        32'd0);
    check("late_ack_cyc", 32'(cyc_hi - b_cyc),  32'd16);
    $display("step ack on last cycle: err=%0d", last_err);

    ack_lat = 16;
    issue(2'b00, 8'h00, 32'h0BAD_0002, 1'b1);
    check("too_late_wr",  32'(wr_cnt - b_wr),   32'd0);
    check("too_late_err", 32'(last_err),       32'd1);
    ack_lat = 2;
    $display("step ack one cycle too late: err=%0d", last_err);

    issue(2'b11, 8'h33, 32'h0, 1'b1);
    check("illegal_cyc", 32'(cyc_hi - b_cyc), 32'd0);
    check("illegal_err", 32'(last_err),       32'd3);
    $display("step illegal op: err=%0d", last_err);

    busy_n = 1000; busy_val = 32'h2;
    issue(2'b10, 8'h22, 32'h0, 1'b1);
    check("stuck_status_rd", 32'(st_cnt - b_st), 32'd64);
    check("stuck_err",       32'(last_err),      32'd2);
    check("stuck_fetch",     32'(fetch_cnt - b_fetch), 32'd0);
    check("stuck_data",      last_data,          32'd0);
    $display("step stuck busy: status reads=%0d err=%0d", st_cnt - b_st, last_err);

    busy_n = 1000; busy_val = 32'h1;
    issue(2'b01, 8'h30, 32'h1, 1'b0);
    for (int i = 0; i < 500 && (st_cnt - b_st) < 3; i++) @(negedge clk);
    check("midrst_reached_poll", 32'((st_cnt - b_st) >= 3), 32'd1);
    wait (bus.wb_cyc_o === 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cyc",       32'(bus.wb_cyc_o), 32'd0);
    check("midrst_stb",       32'(bus.wb_stb_o), 32'd0);
    check("midrst_cmd_ready", 32'(cmd_ready),    32'd1);
    rst = 1'b0;
    b_cyc = cyc_hi;
    repeat (30) @(negedge clk);
    check("midrst_no_rsp",     32'(rsp_cnt - b_rsp), 32'd0);
    check("midrst_no_restart", 32'(cyc_hi - b_cyc),  32'd0);
    check("midrst_ready_after", 32'(cmd_ready),      32'd1);
    $display("step reset during poll: rsp pulses=%0d", rsp_cnt - b_rsp);

    busy_n = 0;
    issue(2'b00, 8'h00, 32'h7777_0000, 1'b1);
    check("after_rst_wr_dat", last_wr_dat,    32'h7777_0000);
    check("after_rst_err",    32'(last_err),  32'd0);
    $display("step key write after reset: err=%0d", last_err);

    check("protocol_violations", 32'(viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/secmem_wb_master.md
SECMEM_WB_MASTER -- requirements
Module: secmem_wb_master

Interface
REQ-001 SHALL have parameter ADDR_WD, default 8, Wishbone address width.
REQ-002 SHALL have parameter DATA_WD, default 32, Wishbone data width; only 32 is supported.
REQ-003 SHALL have parameter ACK_TO, default 16, the maximum number of cycles to wait for wb_ack_i per Wishbone cycle.
REQ-004 SHALL have parameter POLL_MAX, default 64, the maximum number of status reads per command.
REQ-005 wb_clk_i  in  1  clock; all logic on the rising edge.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 cmd_valid_i  in  1  command request.
REQ-008 cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
REQ-009 cmd_op_i  in  2  operation: 00 key write, 01 data write, 10 data read, 11 illegal.
REQ-010 cmd_addr_i  in  ADDR_WD  target address.
REQ-011 cmd_data_i  in  32  write data.
REQ-012 rsp_valid_o  out  1  one-cycle completion pulse.
REQ-013 rsp_data_o  out  32  read data; valid while rsp_valid_o is high.
REQ-014 rsp_err_o  out  2  error code: 00 ok, 01 ack timeout, 10 poll limit, 11 illegal op; valid while rsp_valid_o is high.
REQ-015 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls.
REQ-016 wb_adr_o  out  ADDR_WD; wb_dat_o  out  32; wb_sel_o  out  4  Wishbone master address, data and byte select.
REQ-017 wb_dat_i  in  32; wb_ack_i  in  1  Wishbone slave response.

Function
REQ-018 States SHALL be IDLE, KEY_WR, DAT_WR, DAT_RD, POLL, FETCH and RESP.
REQ-019 cmd_ready_o SHALL be high only in IDLE; command fields SHALL be registered on acceptance.
REQ-020 Accepted op 00 -> KEY_WR; 01 -> DAT_WR; 10 -> DAT_RD; 11 -> RESP with err 11 and no Wishbone cycle.
REQ-021 Every Wishbone cycle: cyc/stb/we/adr/dat/sel SHALL be registered and held stable until the cycle in which wb_ack_i is sampled high.
REQ-022 Wishbone cycle boundaries: cyc and stb SHALL deassert on the edge after ack; there SHALL be at least one idle cycle between Wishbone cycles.
REQ-023 wb_sel_o SHALL be 4'hF on every cycle.
REQ-024 wb_ack_i SHALL be ignored while wb_cyc_o is low.
REQ-025 KEY_WR SHALL perform a write to address 0 with cmd data, then go to RESP with err 00.
REQ-026 DAT_WR SHALL perform a write to cmd_addr with cmd data, then go to POLL watching status bit 0 (wr_busy).
REQ-027 DAT_RD SHALL perform a read of cmd_addr (data discarded), then go to POLL watching status bit 1 (rd_busy).
REQ-028 POLL SHALL read address 2; if the watched bit is 0, the FSM SHALL proceed.
REQ-029 After a clear status bit, DAT_WR SHALL go to RESP with err 00 and DAT_RD SHALL go to FETCH.
REQ-030 If the watched bit is still 1, POLL SHALL increment the poll counter and repeat the read.
REQ-031 Reaching POLL_MAX reads with the watched bit still set -> RESP with err 10.
REQ-032 FETCH SHALL read address 1 and capture wb_dat_i into rsp_data_o, then go to RESP with err 00.
REQ-033 Ack timeout: counter cleared at each cycle start; if ACK_TO cycles elapse without ack, the FSM SHALL drop cyc/stb on the next edge and go to RESP with err 01.
REQ-034 RESP SHALL assert rsp_valid_o for exactly one cycle, then return to IDLE.
REQ-035 rsp_data_o SHALL be 0 for any command other than a successful read.
REQ-036 The poll counter SHALL saturate at POLL_MAX and never wrap.
REQ-037 An ack that coincides with the final timeout cycle SHALL count as success.

Reset
REQ-038 On rst the FSM SHALL go to IDLE and counters SHALL clear.
REQ-039 Output values after rst: wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0, wb_sel_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, cmd_ready_o=1 from the first cycle after reset.
REQ-040 rst asserted mid-cycle SHALL drop cyc/stb at that edge; no rsp_valid_o SHALL be generated for the aborted command.

Verification
REQ-041 Key write: op 00, data 32'h1234_5678, slave acks after 2 cycles -> one write, adr 0, dat 32'h12345678, sel F; rsp_valid with err 00.
REQ-042 Data write: op 01, addr 8'h10; slave returns status 32'h1 twice, then 32'h0 -> three reads of adr 2; rsp err 00.
REQ-043 Data read: op 10, addr 8'h20; status 32'h2, then 0; adr 1 returns 32'hDEADBEEF -> rsp_data 32'hDEADBEEF, err 00.
REQ-044 No ack: op 01, slave never acks -> cyc drops after 16 cycles; rsp err 01.
REQ-045 Illegal op and stuck busy: op 11 -> rsp err 11 with no cyc; op 10 with status always 32'h2 -> exactly 64 status reads, then err 10.
REQ-046 Reset mid-operation: rst during POLL -> cyc=0 next cycle, no rsp_valid, cmd_ready=1 after reset.
